// File: rtl/div_share_arb.sv
// Round-robin arbiter in front of one shared iterative signed restoring divider.
// Define DIV_SHARE_FIXED_PRIO_EN to get fixed priority (lowest index wins) instead.
module div_share_arb #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned WA   = 22,
  parameter int unsigned WB   = 17,
  localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*WA-1:0]   a_flat,
  input  logic [NREQ*WB-1:0]   b_flat,
  output logic [NREQ-1:0]      gnt,
  output logic                 busy,
  output logic                 out_valid,
  output logic [IDW-1:0]       out_id,
  output logic [WA-1:0]        quot,
  output logic [WB-1:0]        rem,
  output logic                 dbz
);

  localparam int unsigned CW = (WA > 1) ? $clog2(WA) : 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StCalc = 2'd1;
  localparam logic [1:0] StSign = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  logic [1:0]     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [WA-1:0]  qacc_q, qacc_d;   // dividend magnitude shifting out, quotient shifting in
  logic [WB-1:0]  pr_q, pr_d;
  logic [WB-1:0]  bmag_q, bmag_d;
  logic           qneg_q, qneg_d;
  logic           rneg_q, rneg_d;
  logic           zero_q, zero_d;
  logic [IDW-1:0] id_q, id_d;
  logic [WA-1:0]  quot_q, quot_d;
  logic [WB-1:0]  rem_q, rem_d;
  logic           dbz_q, dbz_d;
  logic [IDW-1:0] out_id_q, out_id_d;
`ifndef DIV_SHARE_FIXED_PRIO_EN
  logic [IDW-1:0] last_q, last_d;
  logic [IDW-1:0] idx;
`endif

  logic           win_vld;
  logic [IDW-1:0] win_id;
  logic [WA-1:0]  a_sel;
  logic [WB-1:0]  b_sel;
  logic [WB:0]    shifted;
  logic [WB:0]    diff;
  logic           qbit;

  // Winner selection
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
`ifdef DIV_SHARE_FIXED_PRIO_EN
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        win_vld = 1'b1;
        win_id  = IDW'(i);
      end
    end
`else
    idx = last_q;
    for (int k = 0; k < NREQ; k++) begin
      idx = (idx == IDW'(NREQ - 1)) ? '0 : idx + 1'b1;
      if (!win_vld && req[idx]) begin
        win_vld = 1'b1;
        win_id  = idx;
      end
    end
`endif
  end

  assign a_sel = a_flat[win_id*WA +: WA];
  assign b_sel = b_flat[win_id*WB +: WB];

  always_comb begin
    gnt = '0;
    if (state_q == StIdle && win_vld) begin
      gnt[win_id] = 1'b1;
    end
  end

  // One restoring step: bring in the next dividend bit, subtract if it fits.
  assign shifted = {pr_q, qacc_q[WA-1]};
  assign diff    = shifted - {1'b0, bmag_q};
  assign qbit    = (shifted >= {1'b0, bmag_q});

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    qacc_d   = qacc_q;
    pr_d     = pr_q;
    bmag_d   = bmag_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    zero_d   = zero_q;
    id_d     = id_q;
    quot_d   = quot_q;
    rem_d    = rem_q;
    dbz_d    = dbz_q;
    out_id_d = out_id_q;
`ifndef DIV_SHARE_FIXED_PRIO_EN
    last_d   = last_q;
`endif
    case (state_q)
      StIdle: begin
        if (win_vld) begin
          state_d = StCalc;
          cnt_d   = '0;
          qacc_d  = a_sel[WA-1] ? -a_sel : a_sel;
          bmag_d  = b_sel[WB-1] ? -b_sel : b_sel;
          pr_d    = '0;
          qneg_d  = a_sel[WA-1] ^ b_sel[WB-1];
          rneg_d  = a_sel[WA-1];
          zero_d  = (b_sel == '0);
          id_d    = win_id;
`ifndef DIV_SHARE_FIXED_PRIO_EN
          last_d  = win_id;
`endif
        end
      end
      StCalc: begin
        pr_d   = qbit ? diff[WB-1:0] : shifted[WB-1:0];
        qacc_d = {qacc_q[WA-2:0], qbit};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CW'(WA - 1)) begin
          state_d = StSign;
        end
      end
      StSign: begin
        out_id_d = id_q;
        if (zero_q) begin
          quot_d = '0;
          rem_d  = '0;
          dbz_d  = 1'b1;
        end else begin
          quot_d = qneg_q ? -qacc_q : qacc_q;
          rem_d  = rneg_q ? -pr_q : pr_q;
          dbz_d  = 1'b0;
        end
        state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      qacc_q   <= '0;
      pr_q     <= '0;
      bmag_q   <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      zero_q   <= 1'b0;
      id_q     <= '0;
      quot_q   <= '0;
      rem_q    <= '0;
      dbz_q    <= 1'b0;
      out_id_q <= '0;
`ifndef DIV_SHARE_FIXED_PRIO_EN
      last_q   <= IDW'(NREQ - 1);
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      qacc_q   <= qacc_d;
      pr_q     <= pr_d;
      bmag_q   <= bmag_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      zero_q   <= zero_d;
      id_q     <= id_d;
      quot_q   <= quot_d;
      rem_q    <= rem_d;
      dbz_q    <= dbz_d;
      out_id_q <= out_id_d;
`ifndef DIV_SHARE_FIXED_PRIO_EN
      last_q   <= last_d;
`endif
    end
  end

  assign busy      = (state_q != StIdle);
  assign out_valid = (state_q == StDone);
  assign out_id    = out_id_q;
  assign quot      = quot_q;
  assign rem       = rem_q;
  assign dbz       = dbz_q;

endmodule

// File: tb/tb_div_share_arb.sv
// Self-checking bench for div_share_arb: directed cases plus randomized requests
// compared against an arithmetic reference and an arbitration model.
module tb_div_share_arb;

  localparam int NREQ = 3;
  localparam int WA   = 22;
  localparam int WB   = 17;
  localparam int IDW  = 2;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [NREQ-1:0]     req = '0;
  logic [NREQ*WA-1:0]  a_flat;
  logic [NREQ*WB-1:0]  b_flat;
  logic [NREQ-1:0]     gnt;
  logic                busy;
  logic                out_valid;
  logic [IDW-1:0]      out_id;
  logic [WA-1:0]       quot;
  logic [WB-1:0]       rem;
  logic                dbz;

  logic signed [WA-1:0] a_op [NREQ];
  logic signed [WB-1:0] b_op [NREQ];

  int checks = 0;
  int errors = 0;
  int model_last = NREQ - 1;

  div_share_arb #(.NREQ(NREQ), .WA(WA), .WB(WB)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .a_flat    (a_flat),
    .b_flat    (b_flat),
    .gnt       (gnt),
    .busy      (busy),
    .out_valid (out_valid),
    .out_id    (out_id),
    .quot      (quot),
    .rem       (rem),
    .dbz       (dbz)
  );

  always #5 clk = ~clk;

  always_comb begin
    a_flat = '0;
    b_flat = '0;
    for (int i = 0; i < NREQ; i++) begin
      a_flat[i*WA +: WA] = a_op[i];
      b_flat[i*WB +: WB] = b_op[i];
    end
  end

  function automatic int exp_winner(input logic [NREQ-1:0] m);
`ifdef DIV_SHARE_FIXED_PRIO_EN
    for (int i = 0; i < NREQ; i++) if (m[i]) return i;
`else
    for (int k = 1; k <= NREQ; k++) if (m[(model_last + k) % NREQ]) return (model_last + k) % NREQ;
`endif
    return -1;
  endfunction

  task automatic ref_div(input logic signed [WA-1:0] a, input logic signed [WB-1:0] b,
                         output logic [WA-1:0] q, output logic [WB-1:0] r, output logic z);
    longint la;
    longint lb;
    la = a;
    lb = b;
    if (lb == 0) begin
      q = '0; r = '0; z = 1'b1;
    end else begin
      q = WA'(la / lb); r = WB'(la % lb); z = 1'b0;
    end
  endtask

  // One full transaction; pre=1 means req was already driven for the current cycle.
  task automatic job(input logic [NREQ-1:0] m, input bit pre);
    int w;
    int n;
    bit seen;
    logic [WA-1:0] eq;
    logic [WB-1:0] er;
    logic ez;
    w = exp_winner(m);
    if (!pre) begin
      @(posedge clk); #1;
      req = m;
    end
    n = 0;
    @(negedge clk);
    while (gnt == '0 && n < 5) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (gnt !== NREQ'(1 << w)) begin
      errors++;
      $display("FAIL gnt got %b want %b", gnt, NREQ'(1 << w));
    end
    model_last = w;
    ref_div(a_op[w], b_op[w], eq, er, ez);
    @(posedge clk); #1;
    req = '0;
    seen = 0;
    for (int c = 1; c <= WA + 1; c++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
      if (c == 1) begin
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL busy got %b want 1", busy); end
      end
    end
    checks++;
    if (seen) begin errors++; $display("FAIL early_valid got 1 want 0"); end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL out_valid got %b want 1", out_valid); end
    checks++;
    if (quot !== eq) begin errors++; $display("FAIL quot got %h want %h", quot, eq); end
    checks++;
    if (rem !== er) begin errors++; $display("FAIL rem got %h want %h", rem, er); end
    checks++;
    if (dbz !== ez) begin errors++; $display("FAIL dbz got %b want %b", dbz, ez); end
    checks++;
    if (out_id !== IDW'(w)) begin errors++; $display("FAIL out_id got %0d want %0d", out_id, w); end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL after_done got valid=%b busy=%b want 0 0", out_valid, busy);
    end
    checks++;
    if (quot !== eq) begin errors++; $display("FAIL quot_hold got %h want %h", quot, eq); end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({gnt, busy, out_valid, out_id, quot, rem, dbz} !== '0) begin
      errors++;
      $display("FAIL reset got gnt=%b busy=%b v=%b id=%0d q=%h r=%h dbz=%b want all 0",
               gnt, busy, out_valid, out_id, quot, rem, dbz);
    end
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_basic();
    a_op[0] = 22'sd100; b_op[0] = 17'sd7;
    job(3'b001, 0);
  endtask

  task automatic test_signs();
    a_op[1] = -22'sd100; b_op[1] = 17'sd7;
    job(3'b010, 0);
    a_op[1] = 22'sd100; b_op[1] = -17'sd7;
    job(3'b010, 0);
  endtask

  task automatic test_dbz();
    a_op[2] = 22'sd55; b_op[2] = 17'sd0;
    job(3'b100, 0);
    b_op[2] = 17'sd5;
    job(3'b100, 0);
  endtask

  task automatic test_overflow();
    a_op[0] = 22'h200000; b_op[0] = -17'sd1;
    job(3'b001, 0);
  endtask

  task automatic test_round_robin();
    int n;
    int w;
    for (int i = 0; i < NREQ; i++) begin
      a_op[i] = WA'($urandom); b_op[i] = WB'($urandom);
    end
    @(posedge clk); #1;
    req = '1;
    for (int g = 0; g < 5; g++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (gnt == '0 && n < 40);
      w = exp_winner('1);
      checks++;
      if (gnt !== NREQ'(1 << w)) begin errors++; $display("FAIL rr_gnt got %b want %b", gnt, NREQ'(1 << w)); end
      if (g > 0) begin
        checks++;
        if (n != WA + 3) begin errors++; $display("FAIL rr_spacing got %0d want %0d", n, WA + 3); end
      end
      model_last = w;
    end
    @(posedge clk); #1;
    req = '0;
    repeat (WA + 3) @(negedge clk);
  endtask

  task automatic test_random();
    logic [NREQ-1:0] m;
    int sel;
    for (int it = 0; it < 25; it++) begin
      for (int i = 0; i < NREQ; i++) begin
        a_op[i] = ($urandom_range(0, 7) == 0) ? 22'h200000 : WA'($urandom);
        sel = $urandom_range(0, 9);
        if (sel == 0) b_op[i] = '0;
        else if (sel == 1) b_op[i] = -17'sd1;
        else if (sel == 2) b_op[i] = 17'h10000;
        else if (sel < 6) b_op[i] = WB'($urandom_range(1, 40));
        else b_op[i] = WB'($urandom);
      end
      m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      job(m, 0);
    end
  endtask

  task automatic test_reset_mid();
    a_op[0] = 22'sd12345; b_op[0] = 17'sd3;
    @(posedge clk); #1;
    req = 3'b001;
    @(negedge clk);
    checks++;
    if (gnt !== 3'b001) begin errors++; $display("FAIL mid_gnt got %b want 001", gnt); end
    @(posedge clk); #1;
    req = '0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int c = 10; c <= 11; c++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || quot !== '0 || gnt !== '0) begin
        errors++;
        $display("FAIL in_reset got busy=%b v=%b q=%h gnt=%b want 0", busy, out_valid, quot, gnt);
      end
      @(posedge clk);
    end
    #1;
    rst = 1'b1;
    req = 3'b010;
    model_last = NREQ - 1;
    a_op[1] = -22'sd999; b_op[1] = 17'sd10;
    job(3'b010, 1);
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      a_op[i] = '0; b_op[i] = '0;
    end
    test_reset();
    test_basic();
    test_signs();
    test_dbz();
    test_overflow();
    test_round_robin();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
